// File: rtl/present_key_schedule_if.sv
// Handshake bundle between the PRESENT key scheduler and its round-key consumer.
// Optional feature macro: KSCHED_REVERSE_EN (adds the reverse request bit).
interface present_key_schedule_if;
    logic        start;
    logic [19:0] master_key;
`ifdef KSCHED_REVERSE_EN
    logic        reverse;
`endif
    logic        busy;
    logic        rk_valid;
    logic        rk_ready;
    logic [15:0] rk;
    logic [4:0]  rk_index;
    logic        done;

`ifdef KSCHED_REVERSE_EN
    modport master (
        output start, master_key, reverse, rk_ready,
        input  busy, rk_valid, rk, rk_index, done
    );
    modport slave (
        input  start, master_key, reverse, rk_ready,
        output busy, rk_valid, rk, rk_index, done
    );
`else
    modport master (
        output start, master_key, rk_ready,
        input  busy, rk_valid, rk, rk_index, done
    );
    modport slave (
        input  start, master_key, rk_ready,
        output busy, rk_valid, rk, rk_index, done
    );
`endif
endinterface

// File: rtl/present_key_schedule.sv
// PRESENT-style round-key generator: 20-bit master key, 16-bit round keys,
// ROUNDS+1 keys emitted one per valid/ready handshake.
// Optional feature macro: KSCHED_REVERSE_EN (precompute all keys into a buffer
// and emit them from index ROUNDS down to 0).
module present_key_schedule #(
    parameter int unsigned ROUNDS = 31
) (
    input  logic               clk,
    input  logic               rst,
    present_key_schedule_if.slave ks
);

    localparam logic [4:0] LAST = 5'(ROUNDS);

`ifdef KSCHED_REVERSE_EN
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DONE, S_FILL, S_RUNREV} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [19:0] key;
    logic [4:0]  count;

`ifdef KSCHED_REVERSE_EN
    logic        rev_mode;
    logic [15:0] key_buf [0:ROUNDS];
`endif

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
            4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
            4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
            4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [19:0] key_update(input logic [19:0] k, input logic [4:0] r);
        logic [19:0] t;
        t        = {k[6:0], k[19:7]};
        t[19:16] = sbox(t[19:16]);
        t[8:4]   = t[8:4] ^ r;
        return t;
    endfunction

    // State register; reset aborts any run immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (ks.start) begin
`ifdef KSCHED_REVERSE_EN
                    state_nxt = ks.reverse ? S_FILL : S_RUN;
`else
                    state_nxt = S_RUN;
`endif
                end
            end
            S_RUN:    if (ks.rk_ready && count == LAST) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
`ifdef KSCHED_REVERSE_EN
            S_FILL:   if (count == LAST) state_nxt = S_RUNREV;
            S_RUNREV: if (ks.rk_ready && count == 5'd0) state_nxt = S_DONE;
`endif
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Key register and round counter; both freeze while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key   <= '0;
            count <= '0;
`ifdef KSCHED_REVERSE_EN
            rev_mode <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (ks.start) begin
                        key   <= ks.master_key;
                        count <= '0;
`ifdef KSCHED_REVERSE_EN
                        rev_mode <= ks.reverse;
`endif
                    end
                end
                S_RUN: begin
                    if (ks.rk_ready && count != LAST) begin
                        key   <= key_update(key, 5'(count + 5'd1));
                        count <= 5'(count + 5'd1);
                    end
                end
`ifdef KSCHED_REVERSE_EN
                // Counter parks at LAST when the fill ends, ready to count down.
                S_FILL: begin
                    if (count != LAST) begin
                        key   <= key_update(key, 5'(count + 5'd1));
                        count <= 5'(count + 5'd1);
                    end
                end
                S_RUNREV: begin
                    if (ks.rk_ready && count != 5'd0) count <= 5'(count - 5'd1);
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef KSCHED_REVERSE_EN
    // Key buffer captures one round key per fill cycle.
    always_ff @(posedge clk) begin
        if (state == S_FILL) key_buf[count] <= key[19:4];
    end
`endif

    // Output decode; rk/rk_index come straight from held registers.
    always_comb begin
        ks.busy     = 1'b0;
        ks.rk_valid = 1'b0;
        ks.done     = 1'b0;
        unique case (state)
            S_RUN:    begin ks.busy = 1'b1; ks.rk_valid = 1'b1; end
            S_DONE:   ks.done = 1'b1;
`ifdef KSCHED_REVERSE_EN
            S_FILL:   ks.busy = 1'b1;
            S_RUNREV: begin ks.busy = 1'b1; ks.rk_valid = 1'b1; end
`endif
            default:  ;
        endcase
        ks.rk_index = count;
`ifdef KSCHED_REVERSE_EN
        ks.rk = rev_mode ? key_buf[count] : key[19:4];
`else
        ks.rk = key[19:4];
`endif
    end

endmodule

// File: doc/present_key_schedule.md
Name: present_key_schedule

Overview:
- Sequential round-key generator that sits directly upstream of the PRESENT round datapath (20-bit master key, 16-bit block).
- Expands a 20-bit master key into ROUNDS+1 16-bit round keys.
- Emits one key per valid/ready handshake, so an iterative encipher or decipher stage can consume keys at its own pace.

Parameters:
- ROUNDS, 31, number of key-update rounds; keys emitted = ROUNDS+1; legal range 1..31.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request; samples master_key; honoured only in IDLE.
- master_key  input  20  master key, sampled on accepted start.
- busy  output  1  high from the cycle after an accepted start through the last handshake.
- rk_valid  output  1  round key on rk is valid.
- rk_ready  input  1  consumer accepts rk this cycle.
- rk  output  16  current round key.
- rk_index  output  5  index of rk (0..ROUNDS).
- done  output  1  one-cycle pulse after the final key is accepted.

Behaviour:
- Reset, asynchronous active-high: state=IDLE; key register=0; counter=0; busy=0; rk_valid=0; rk=0; rk_index=0; done=0. Reset mid-operation aborts immediately, no done pulse.
- States:
  - IDLE: start=1 -> load K0=master_key, counter=0, go to RUN. busy and rk_valid go high the next cycle.
  - RUN: rk=K[19:4], rk_index=counter, rk_valid=1.
    - On rk_valid&&rk_ready with counter<ROUNDS: K <= update(K, counter+1); counter++.
    - On the handshake with counter==ROUNDS: go to DONE.
  - DONE: done=1 and busy=0 for one cycle, rk_valid=0, then IDLE. rk/rk_index hold their last values.
- Update(K, r):
  - t = {K[6:0], K[19:7]}, i.e. rotate left by 13.
  - t[19:16] = S(t[19:16]), using the PRESENT S-box 0..F -> C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2.
  - t[8:4] ^= r[4:0].
  - Result is t.
- Latency: first key valid 1 cycle after start. With rk_ready tied high, one key per cycle; ROUNDS+1 keys in ROUNDS+1 cycles, done on the following cycle.
- Backpressure: while rk_valid && !rk_ready, rk and rk_index are held stable and K is not updated.
- start while busy or in DONE: ignored; no restart, no sampling of master_key.
- start in the same cycle as the DONE pulse: ignored. start is honoured from IDLE only.
- Counter never wraps: ROUNDS<=31 and the 5-bit index reaches at most ROUNDS.

Optional Feature:
- Macro: KSCHED_REVERSE_EN.
- Defined:
  - Adds input port reverse (1 bit), sampled with start.
  - Adds a (ROUNDS+1)x16 key buffer.
  - If reverse=1 at start: enter FILL state, busy=1, rk_valid=0. Compute and store K0..K_ROUNDS round keys, one per cycle, ROUNDS+1 cycles.
  - Then enter RUN-reverse: emit buffer entries with rk_index ROUNDS down to 0, same handshake and backpressure rules. done follows the index-0 handshake.
  - reverse=0 behaves exactly as the forward mode.
  - Reset mid-FILL aborts like RUN.
- Undefined: no reverse port, no buffer, forward order only.

Test Plan:
- master_key=20'h00000, start, rk_ready=1:
  - rk_index0 rk=16'h0000, index1 rk=16'hC001.
  - 32 handshakes total, then done pulses exactly once; busy low afterwards.
- master_key=20'hFFFFF, start, rk_ready=1:
  - rk_index0 rk=16'hFFFF, index1 rk=16'h2FFE.
  - Final key matches the reference-model value at index31.
- master_key=20'hBEEF5, rk_ready toggled pseudo-randomly:
  - rk=16'hBEEF at index0, held stable during every stall.
  - Key sequence identical to the rk_ready=1 run; no index skipped or repeated.
- start pulsed again at index 10 with a different master_key:
  - Ignored; sequence continues unchanged to index31 and done.
- rst asserted asynchronously at index 5 (mid-cycle):
  - All outputs zero immediately, state IDLE, no done pulse.
  - A new start with 20'h00000 yields rk=16'h0000, then 16'hC001.
- KSCHED_REVERSE_EN, reverse=1, master_key=20'h00000:
  - busy high and rk_valid low for 32 cycles.
  - Then indices 31..0 emitted; index1 rk=16'hC001, index0 rk=16'h0000; done after index0.
